// File: rtl/regfile_exec_seq_if.sv
// Instruction handshake between the issuing side and regfile_exec_seq.
// Master offers an instruction, slave raises in_ready when it can take one.
interface regfile_exec_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [15:0] in_imm;

  modport master (
    output in_valid,
    output in_op,
    output in_rd,
    output in_rs1,
    output in_rs2,
    output in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_rd,
    input  in_rs1,
    input  in_rs2,
    input  in_imm,
    output in_ready
  );
endinterface

// File: rtl/regfile_exec_seq.sv
// Sequencer for one 16-bit ALU instruction at a time against an external
// register file: IDLE -> READ -> EXEC -> WB, or IDLE -> WB for LI.
module regfile_exec_seq (
  input  logic                      clk,
  input  logic                      rst_n,
  regfile_exec_seq_if.slave         in_if,
  output logic                      readA,
  output logic                      readB,
  output logic [4:0]                rdAddrA,
  output logic [4:0]                rdAddrB,
  input  logic [15:0]               rdDataA,
  input  logic [15:0]               rdDataB,
  output logic                      write,
  output logic [4:0]                wrAddr,
  output logic [15:0]               wrData,
  output logic                      done,
  output logic                      flag_z,
  output logic                      flag_c
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_LI  = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [15:0] imm_q, imm_d;
  logic        read_q, read_d;
  logic [4:0]  rd_addr_a_q, rd_addr_a_d;
  logic [4:0]  rd_addr_b_q, rd_addr_b_d;
  logic        write_q, write_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        z_q, z_d;
  logic        c_q, c_d;

  logic [16:0] sum;
  logic [16:0] dif;
  logic [15:0] alu_res;
  logic        alu_c;
  logic        accept;

  assign accept = in_if.in_valid && (state_q == IDLE);

  // ALU on the operands the register file returns during EXEC
  always_comb begin
    sum     = {1'b0, rdDataA} + {1'b0, rdDataB};
    dif     = {1'b0, rdDataA} - {1'b0, rdDataB};
    alu_res = rdDataA;
    alu_c   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = sum[15:0];
        alu_c   = sum[16];
      end
      OP_SUB: begin
        alu_res = dif[15:0];
        alu_c   = dif[16];
      end
      OP_AND: alu_res = rdDataA & rdDataB;
      OP_OR:  alu_res = rdDataA | rdDataB;
      OP_XOR: alu_res = rdDataA ^ rdDataB;
      OP_SHL: alu_res = rdDataA << rdDataB[3:0];
      OP_SHR: alu_res = rdDataA >> rdDataB[3:0];
      OP_LI:  alu_res = rdDataA;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    read_d      = 1'b0;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    write_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    z_d         = z_q;
    c_d         = c_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = in_if.in_op;
          rd_d  = in_if.in_rd;
          rs1_d = in_if.in_rs1;
          rs2_d = in_if.in_rs2;
          imm_d = in_if.in_imm;
          if (in_if.in_op == OP_LI) begin
            state_d   = WB;
            write_d   = 1'b1;
            done_d    = 1'b1;
            wr_addr_d = in_if.in_rd;
            wr_data_d = in_if.in_imm;
          end else begin
            state_d     = READ;
            read_d      = 1'b1;
            rd_addr_a_d = in_if.in_rs1;
            rd_addr_b_d = in_if.in_rs2;
          end
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        state_d   = WB;
        write_d   = 1'b1;
        done_d    = 1'b1;
        wr_addr_d = rd_q;
        wr_data_d = alu_res;
        z_d       = (alu_res == 16'h0000);
        c_d       = alu_c;
      end
      WB: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      read_q      <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      write_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      read_q      <= read_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      write_q     <= write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      z_q         <= z_d;
      c_q         <= c_d;
    end
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign readA   = read_q;
  assign readB   = read_q;
  assign rdAddrA = rd_addr_a_q;
  assign rdAddrB = rd_addr_b_q;
  assign write   = write_q;
  assign wrAddr  = wr_addr_q;
  assign wrData  = wr_data_q;
  assign done    = done_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;

endmodule

// File: tb/tb_regfile_exec_seq.sv
// Bench for regfile_exec_seq: external register file, expected write-backs
// queued at issue time and compared when the DUT writes back.
module tb_regfile_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        readA, readB;
  logic [4:0]  rdAddrA, rdAddrB;
  logic [15:0] rdDataA, rdDataB;
  logic        write;
  logic [4:0]  wrAddr;
  logic [15:0] wrData;
  logic        done;
  logic        flag_z, flag_c;

  regfile_exec_seq_if bus ();

  regfile_exec_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_if   (bus),
    .readA   (readA),
    .readB   (readB),
    .rdAddrA (rdAddrA),
    .rdAddrB (rdAddrB),
    .rdDataA (rdDataA),
    .rdDataB (rdDataB),
    .write   (write),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .done    (done),
    .flag_z  (flag_z),
    .flag_c  (flag_c)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [32];

  always @(posedge clk) begin
    if (readA) rdDataA <= mem[rdAddrA];
    if (readB) rdDataB <= mem[rdAddrB];
    if (write) mem[wrAddr] <= wrData;
  end

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
    logic        z;
    logic        c;
  } exp_t;

  exp_t        sb [$];
  exp_t        got;
  logic [15:0] shadow [32];
  logic        exp_z, exp_c;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [17:0] alu_model(input logic [2:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      3'd0: {c, r} = {1'b0, a} + {1'b0, b};
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      default: r = a;
    endcase
    return {c, (r == 16'h0000), r};
  endfunction

  task automatic push(input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [15:0] imm);
    logic [17:0] m;
    if (op == 3'd7) begin
      shadow[rd] = imm;
    end else begin
      m = alu_model(op, shadow[rs1], shadow[rs2]);
      exp_c = m[17];
      exp_z = m[16];
      shadow[rd] = m[15:0];
    end
    sb.push_back({rd, shadow[rd], exp_z, exp_c});
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [15:0] imm);
    bus.in_op  = op;
    bus.in_rd  = rd;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_imm = imm;
  endtask

  // Offer one instruction, wait (bounded) for acceptance, drop in_valid
  task automatic drive(input logic [2:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [15:0] imm, input bit track);
    int n;
    @(negedge clk);
    set_fields(op, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    if (track) push(op, rd, rs1, rs2, imm);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL idle_timeout in_ready=%b required 1", bus.in_ready);
    end
  endtask

  // Write-back monitor against the scoreboard
  always @(negedge clk) begin
    if (write === 1'b1 || done === 1'b1) begin
      checks++;
      if (done !== write) begin
        errors++;
        $display("FAIL done_eq_write done=%b write=%b", done, write);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h none required",
                 wrAddr, wrData);
      end else begin
        got = sb.pop_front();
        if ({wrAddr, wrData, flag_z, flag_c} !==
            {got.addr, got.data, got.z, got.c}) begin
          errors++;
          $display("FAIL wb addr=%0d data=%h z=%b c=%b required %0d %h %b %b",
                   wrAddr, wrData, flag_z, flag_c,
                   got.addr, got.data, got.z, got.c);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_z = 1'b0;
    exp_c = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready in_ready=%b required 1", bus.in_ready);
    end
    checks++;
    if ({readA, readB, write, done, flag_z, flag_c} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required 000000",
               {readA, readB, write, done, flag_z, flag_c});
    end
    checks++;
    if ({rdAddrA, rdAddrB, wrAddr, wrData} !== 31'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h required 0",
               {rdAddrA, rdAddrB, wrAddr, wrData});
    end
  endtask

  task automatic test_li();
    drive(3'd7, 5'd3, 5'd0, 5'd0, 16'h1234, 1'b1);
    @(negedge clk);
    checks++;
    if ({write, done, wrAddr, wrData} !== {1'b1, 1'b1, 5'd3, 16'h1234}) begin
      errors++;
      $display("FAIL li_wb w=%b d=%b a=%0d data=%h required 1 1 3 1234",
               write, done, wrAddr, wrData);
    end
    checks++;
    if ({bus.in_ready, readA, flag_z, flag_c} !== 4'b0000) begin
      errors++;
      $display("FAIL li_side rdy/rdA/z/c=%b required 0000",
               {bus.in_ready, readA, flag_z, flag_c});
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || write !== 1'b0) begin
      errors++;
      $display("FAIL li_ready in_ready=%b write=%b required 1 0",
               bus.in_ready, write);
    end
  endtask

  task automatic test_add();
    drive(3'd7, 5'd1, 5'd0, 5'd0, 16'hFFFF, 1'b1);
    drive(3'd7, 5'd2, 5'd0, 5'd0, 16'h0001, 1'b1);
    drive(3'd0, 5'd4, 5'd1, 5'd2, 16'h0, 1'b1);
    @(negedge clk);
    checks++;
    if ({readA, readB, rdAddrA, rdAddrB, write} !==
        {1'b1, 1'b1, 5'd1, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL add_read rA=%b rB=%b aA=%0d aB=%0d w=%b required 1 1 1 2 0",
               readA, readB, rdAddrA, rdAddrB, write);
    end
    @(negedge clk);
    checks++;
    if ({readA, readB, write, bus.in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL add_exec rA/rB/w/rdy=%b required 0000",
               {readA, readB, write, bus.in_ready});
    end
    @(negedge clk);
    checks++;
    if ({write, wrAddr, wrData, flag_z, flag_c} !==
        {1'b1, 5'd4, 16'h0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_wb w=%b a=%0d data=%h z=%b c=%b required 1 4 0000 1 1",
               write, wrAddr, wrData, flag_z, flag_c);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_ready in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_alu_ops();
    drive(3'd7, 5'd1, 5'd0, 5'd0, 16'h0003, 1'b1);
    drive(3'd7, 5'd2, 5'd0, 5'd0, 16'h0005, 1'b1);
    drive(3'd1, 5'd5, 5'd1, 5'd2, 16'h0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if ({wrData, flag_z, flag_c} !== {16'hFFFE, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub data=%h z=%b c=%b required fffe 0 1",
               wrData, flag_z, flag_c);
    end
    drive(3'd7, 5'd10, 5'd0, 5'd0, 16'h8001, 1'b1);
    drive(3'd7, 5'd11, 5'd0, 5'd0, 16'h0011, 1'b1);
    drive(3'd5, 5'd12, 5'd10, 5'd11, 16'h0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if ({wrData, flag_c} !== {16'h0002, 1'b0}) begin
      errors++;
      $display("FAIL shl data=%h c=%b required 0002 0", wrData, flag_c);
    end
    drive(3'd7, 5'd13, 5'd0, 5'd0, 16'h0000, 1'b1);
    drive(3'd6, 5'd14, 5'd10, 5'd13, 16'h0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (wrData !== 16'h8001) begin
      errors++;
      $display("FAIL shr0 data=%h required 8001", wrData);
    end
    drive(3'd7, 5'd0, 5'd0, 5'd0, 16'h00FF, 1'b1);
    drive(3'd2, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
    drive(3'd3, 5'd15, 5'd0, 5'd0, 16'h0, 1'b1);
    drive(3'd0, 5'd10, 5'd10, 5'd10, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(3'd7, 5'd20, 5'd0, 5'd0, 16'($urandom), 1'b1);
      drive(3'd7, 5'd21, 5'd0, 5'd0, 16'($urandom), 1'b1);
      drive(3'($urandom_range(0, 6)), 5'($urandom_range(22, 31)),
            5'd20, 5'd21, 16'($urandom), 1'b1);
    end
    drive(3'd0, 5'd22, 5'd22, 5'd23, 16'h0, 1'b1);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    drive(3'd7, 5'd1, 5'd0, 5'd0, 16'h0102, 1'b1);
    wait_idle();
    set_fields(3'd0, 5'd6, 5'd1, 5'd1, 16'h0);
    bus.in_valid = 1'b1;
    push(3'd0, 5'd6, 5'd1, 5'd1, 16'h0);
    @(posedge clk);
    #1 set_fields(3'd0, 5'd7, 5'd6, 5'd6, 16'h0);
    push(3'd0, 5'd7, 5'd6, 5'd6, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy%0d in_ready=%b required 0", i, bus.in_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({readA, rdAddrA, rdAddrB} !== {1'b1, 5'd6, 5'd6}) begin
      errors++;
      $display("FAIL b2b_read rA=%b aA=%0d aB=%0d required 1 6 6",
               readA, rdAddrA, rdAddrB);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({write, wrAddr, wrData} !== {1'b1, 5'd7, 16'h0408}) begin
      errors++;
      $display("FAIL b2b_wb w=%b a=%0d data=%h required 1 7 0408",
               write, wrAddr, wrData);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int w;
    drive(3'd7, 5'd8, 5'd0, 5'd0, 16'h5A5A, 1'b1);
    wait_idle();
    drive(3'd0, 5'd8, 5'd1, 5'd1, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_z = 1'b0;
    exp_c = 1'b0;
    checks++;
    if ({bus.in_ready, write, flag_z, flag_c} !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_state rdy/w/z/c=%b required 1000",
               {bus.in_ready, write, flag_z, flag_c});
    end
    w = 0;
    repeat (6) begin
      @(negedge clk);
      if (write === 1'b1) w++;
    end
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL rstmid_nowrite writes=%0d required 0", w);
    end
    checks++;
    if (mem[8] !== 16'h5A5A) begin
      errors++;
      $display("FAIL rstmid_r8 r8=%h required 5a5a", mem[8]);
    end
  endtask

  task automatic test_busy_random();
    int w;
    drive(3'd0, 5'd9, 5'd1, 5'd8, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy%0d in_ready=%b required 0", i, bus.in_ready);
      end
      set_fields(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom));
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_end in_ready=%b required 1", bus.in_ready);
    end
    w = 0;
    repeat (5) begin
      @(negedge clk);
      if (write === 1'b1 || bus.in_ready !== 1'b1) w++;
    end
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL busy_ignored stray_cycles=%0d required 0", w);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    test_reset();
    test_li();
    test_add();
    test_alu_ops();
    test_back_to_back();
    test_reset_mid();
    test_busy_random();
    wait_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_exec_seq.md
REGFILE_EXEC_SEQ -- requirements
Module: regfile_exec_seq

Interface
REQ-001 Parameters: none; data width is fixed at 16 bits and register address width at 5 bits.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 in_valid  in  1  instruction offered.
REQ-005 in_ready  out  1  block can accept an instruction; high only in IDLE.
REQ-006 in_op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 LI.
REQ-007 in_rd / in_rs1 / in_rs2  in  5 each  destination / source A / source B register.
REQ-008 in_imm  in  16  immediate operand, used by LI only.
REQ-009 readA, readB  out  1 each  read enables to the register file.
REQ-010 rdAddrA, rdAddrB  out  5 each  read addresses.
REQ-011 rdDataA, rdDataB  in  16 each  register file read data, valid one cycle after the read enable.
REQ-012 write  out  1  register file write enable.
REQ-013 wrAddr  out  5  write address.
REQ-014 wrData  out  16  write data.
REQ-015 done  out  1  one-cycle pulse marking the write-back cycle.
REQ-016 flag_z, flag_c  out  1 each  zero and carry of the last executed ALU op.

Function
REQ-017 The FSM SHALL have four states: IDLE, READ, EXEC, WB.
REQ-018 in_ready SHALL equal (state == IDLE).
REQ-019 On in_valid & in_ready, the block SHALL capture op, rd, rs1, rs2 and imm.
- LI: next state WB.
- All other ops: next state READ.
REQ-020 READ SHALL last one cycle and assert readA = readB = 1, rdAddrA = rs1, rdAddrB = rs2.
- All other cycles: readA = readB = 0.
REQ-021 EXEC SHALL last one cycle.
- Computes the result from rdDataA (A) and rdDataB (B) as delivered by the register file.
- Registers the result, flag_z and flag_c at the end of the cycle.
REQ-022 Arithmetic SHALL be 16-bit modulo 2^16.
- ADD: carry = bit 16 of A + B.
- SUB: A - B; carry = borrow, i.e. 1 iff A < B (unsigned).
- AND, OR, XOR: carry = 0.
- SHL / SHR: logical shift of A by B[3:0]; carry = 0; a shift amount of 0 returns A unchanged.
REQ-023 flag_z SHALL be 1 iff the 16-bit result is 0.
- Flags hold their value until the next EXEC.
- LI SHALL NOT alter the flags.
REQ-024 WB SHALL last one cycle and assert write = 1, wrAddr = rd, wrData = the result (the immediate for LI), done = 1; next state IDLE.
REQ-025 write and done SHALL be 0 in every non-WB cycle.
REQ-026 Latency from the acceptance cycle T:
- ALU ops: READ at T+1, EXEC at T+2, WB at T+3, in_ready again at T+4.
- LI: WB at T+1, in_ready at T+2.
REQ-027 Any register 0-31 SHALL be a legal destination, including 0; r0 is not hardwired.
REQ-028 rs1 == rs2, and rd equal to a source, SHALL execute normally; the sources are read before the write.
REQ-029 An instruction accepted at T+4 that reads the register written at T+3 SHALL see the new value; no forwarding is needed because in_ready is low until write-back completes.
REQ-030 in_op/in_rd/in_rs1/in_rs2/in_imm SHALL be ignored whenever in_valid & in_ready is false.

Reset
REQ-031 A rising clock edge with rst_n = 0 SHALL force state IDLE and clear to 0: readA, readB, rdAddrA, rdAddrB, write, wrAddr, wrData, done, flag_z, flag_c and the captured instruction.
REQ-032 Reset mid-operation (READ, EXEC or WB) SHALL abandon the instruction; no write is issued in any later cycle.
- A WB cycle coinciding with rst_n = 0 still presents write = 1 in that cycle, because outputs are registered and the register file has no reset. This behaviour is accepted.
REQ-033 From the first cycle after the reset edge, in_ready SHALL be 1.

Verification
REQ-034 After reset: LI rd=3 imm=0x1234 accepted at T -> write=1, wrAddr=3, wrData=0x1234, done=1 at T+1; in_ready=1 at T+2; flags unchanged (0,0).
REQ-035 Given r1=0xFFFF and r2=0x0001, ADD rd=4 rs1=1 rs2=2 -> readA/readB at T+1 with addresses 1/2; write at T+3 with wrData=0x0000; flag_z=1, flag_c=1.
REQ-036 Given r1=0x0003 and r2=0x0005, SUB rd=5 -> wrData=0xFFFE, flag_c=1, flag_z=0.
- SHL with A=0x8001, B=0x0011 -> 0x0002 (shift by 1).
- SHR with B=0x0000 -> A.
REQ-037 Back-to-back sequence: ADD r6=r1+r1, then ADD r7=r6+r6 with in_valid held high -> second accepted exactly 4 cycles after the first and reads the updated r6; in_ready=0 in the three intervening cycles.
REQ-038 Reset asserted during EXEC of ADD rd=8 -> no write in any later cycle; r8 unchanged; state IDLE; in_ready=1 the cycle after reset.
REQ-039 in_valid high with random fields while busy -> fields ignored; the instruction is accepted only when in_ready=1.
